rr_arb4: RTL
============

Name: rr_arb4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource (bus/port) between requesters 0..3.
- Grants are one-hot; at most one requester holds the resource at a time.
- Holds the grant until the holder releases, drops its request, or exceeds a configurable hold limit.
- Priority rotates so that no requester starves.

Parameters:
- MAX_HOLD, 16, max consecutive grant cycles per tenure; 0 disables the timeout.
- CW, 8, width of the hold counter; must satisfy MAX_HOLD < 2^CW.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  4  request lines; bit i = requester i; level-sensitive.
- done  input  1  release pulse from the current holder; ignored when not busy.
- grant  output  4  one-hot grant; all zero when idle.
- grant_idx  output  2  binary index of the current or last holder.
- busy  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD.

Behaviour:
- Reset (rst_n low at a clk edge):
  - grant=0000, grant_idx=00, busy=0, timeout=0.
  - Priority pointer ptr=00, hold counter=0, state=IDLE.
  - Reset mid-tenure drops the grant on that edge. There is no drain.
- States: IDLE, GRANT, all outputs registered.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: grant_idx=winner, grant=one-hot(winner), busy=1, counter=0, go to GRANT.
  - Latency is 1 cycle from sampled req to grant.
  - If req == 0, stay in IDLE with outputs unchanged, except grant=0000 and busy=0.
- GRANT: counter increments every cycle. The tenure ends at an edge where any of these holds:
  - (a) done=1.
  - (b) req[grant_idx]=0.
  - (c) MAX_HOLD != 0 and counter == MAX_HOLD-1.
- On tenure end:
  - grant=0000, busy=0, ptr=grant_idx+1 (mod 4, 11 wraps to 00), go to IDLE.
  - timeout=1 for that one cycle only if (c) caused the end and neither (a) nor (b) was true.
- Simultaneous (a)/(b)/(c): a normal release takes precedence, so timeout=0.
- There is always one idle bubble cycle between tenures. Back-to-back grants to different requesters are therefore separated by exactly 1 cycle with grant=0000.
- grant_idx holds the last holder while idle; it changes only when a new grant is issued.
- Requests from non-holders during GRANT are not latched. They are only seen through req levels in IDLE.
- grant is always one-hot or zero. It never has two bits set, including across reset.
- Arithmetic: ptr and grant_idx are 2-bit with natural wrap. The counter is CW bits and never exceeds MAX_HOLD-1 while MAX_HOLD != 0. With MAX_HOLD=0 it saturates at all-ones.

Decomposition:
- Shared include/package:
  - State encodings: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Requester count constant NREQ=4.
  - Index width constant IDXW=2.
- Sub-module: grant one-hot decoding reuses the team's existing 2-to-4 decoder, dec24. Inputs are grant_idx[1], grant_idx[0]; its output is gated with busy to form grant.
- The rotate-priority select is a small combinational function inside rr_arb4. No separate module is needed.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req=1111 -> grant=0000, busy=0, grant_idx=00, timeout=0 throughout.
- Single requester: req=0100 from idle, done pulse 5 cycles after grant.
  - Expect grant=0100, grant_idx=10 one cycle after req.
  - Grant drops on the done edge.
  - Next priority goes to requester 3.
- Rotation: req=1111 held, each holder pulses done 2 cycles into its tenure -> grant sequence 0001, 0010, 0100, 1000, 0001, with one 0000 cycle between each.
- Timeout: MAX_HOLD=4, req=0010 held, done=0 -> grant=0010 for exactly 4 cycles, then timeout=1 with grant=0000 for 1 cycle, then regrant 0010 on the following cycle.
- Simultaneous end: on the timeout cycle, also drop req[1] -> grant drops and timeout stays 0.
- Reset mid-tenure, plus an ignored done:
  - Assert rst_n=0 while grant=1000 -> grant=0000 next edge, ptr=00, so req=1001 afterwards grants 0001.
  - A done pulse while idle does not change any output.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package rr_arb4_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dec24.sv
// 2-to-4 one-hot decoder: y[i] is high when {a1,a0} == i.
module dec24 (
  input  logic       a1,
  input  logic       a0,
  output logic [3:0] y
);

  logic [1:0] sel;

  assign sel = {a1, a0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dec
      assign y[gi] = (sel == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter for four requesters sharing one downstream resource.
// A tenure lasts until done, until the holder drops its request, or until
// MAX_HOLD cycles have elapsed; one idle cycle always separates tenures.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            busy,
  output logic            timeout
);

  // Counter value on the last allowed cycle of a tenure; unused when MAX_HOLD is 0.
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  state_t          state_reg, state_next;
  logic [IDXW-1:0] ptr_reg, ptr_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            busy_reg, busy_next;
  logic            timeout_reg, timeout_next;

  logic            release_hit;
  logic            limit_hit;
  logic [IDXW-1:0] winner;
  logic [NREQ-1:0] dec_y;

  // First requesting index found scanning ptr, ptr+1, ... with 2-bit wrap.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDXW-1:0] p);
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] cand;
    logic            found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = p + IDXW'(k);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner      = rr_pick(req, ptr_reg);
  assign release_hit = done || !req[idx_reg];
  assign limit_hit   = (MAX_HOLD != 0) && (cnt_reg == HOLD_LAST);

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    cnt_next     = cnt_reg;
    busy_next    = busy_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy_next = 1'b0;
        if (|req) begin
          state_next = ST_GRANT;
          idx_next   = winner;
          busy_next  = 1'b1;
          cnt_next   = '0;
        end
      end
      ST_GRANT: begin
        if (release_hit || limit_hit) begin
          state_next   = ST_IDLE;
          busy_next    = 1'b0;
          ptr_next     = idx_reg + IDXW'(1);
          cnt_next     = '0;
          // A normal release on the same edge wins over the hold limit.
          timeout_next = limit_hit && !release_hit;
        end else if ((MAX_HOLD != 0) || (cnt_reg != CNT_SAT)) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any grant on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  dec24 u_dec (
    .a1 (idx_reg[1]),
    .a0 (idx_reg[0]),
    .y  (dec_y)
  );

  assign grant     = dec_y & {NREQ{busy_reg}};
  assign grant_idx = idx_reg;
  assign busy      = busy_reg;
  assign timeout   = timeout_reg;

endmodule
